fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_unit_sat_counter.sv | 27 ++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the program-sequencing core.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int unsigned FLAG_CARRY   = 0;
  localparam int unsigned FLAG_ZERO    = 1;
  localparam int unsigned FLAG_GREATER = 2;

endpackage

// File: rtl/fetch_unit_sat_counter.sv
// Saturating up-counter with synchronous clear and a registered at-max flag.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_max
);

  // at_max tracks count == all-ones, registered alongside the count itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      at_max <= 1'b0;
    end else if (clr) begin
      count  <= '0;
      at_max <= 1'b0;
    end else if (inc && !at_max) begin
      count  <= count + W'(1);
      at_max <= (count == ~W'(1));
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Program sequencer: PC with absolute/relative jumps, run/halt FSM, stall, flags, perf counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W       = 16,
  parameter int unsigned OFFS_W     = 8,
  parameter int unsigned FLAG_W     = 3,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              jump_en,
  input  logic              jump_rel,
  input  logic [PC_W-1:0]   jump_target,
  input  logic [OFFS_W-1:0] jump_offset,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [FLAG_W-1:0] flags_en,
  output logic [PC_W-1:0]   PC,
  output logic [FLAG_W-1:0] flags,
  output logic              running,
  output logic              halt,
  output logic [CNT_W-1:0]  cycle_ct,
  output logic [CNT_W-1:0]  instr_ct,
  output logic              cnt_sat
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  fetch_state_t      state_q;
  logic [PC_W-1:0]   pc_q;
  logic [FLAG_W-1:0] flags_q;
  logic [PC_W-1:0]   pc_next_c;
  logic [FLAG_W-1:0] flags_next_c;
  logic              cyc_at_max;
  logic              ins_at_max;
  logic              retire_c;

  // Next PC for a non-stalled, non-halting RUN cycle
  always_comb begin
    pc_next_c = pc_q + PC_W'(1);
    if (jump_en) begin
      if (jump_rel) pc_next_c = pc_q + PC_W'($signed(jump_offset));
      else          pc_next_c = jump_target;
    end
  end

  assign flags_next_c = (flags_q & ~flags_en) | (flags_in & flags_en);
  assign retire_c     = (state_q == RUN) && !stall;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      flags_q <= '0;
    end else if (start) begin
      state_q <= RUN;
      pc_q    <= START_PC;
      flags_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (!stall) begin
            flags_q <= flags_next_c;
            if (halt_req) state_q <= HALTED;
            else          pc_q    <= pc_next_c;
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_ct (
    .clk    (CLK),
    .rst_n  (reset_n),
    .clr    (start),
    .inc    (state_q == RUN),
    .count  (cycle_ct),
    .at_max (cyc_at_max)
  );

  sat_counter #(.W(CNT_W)) u_instr_ct (
    .clk    (CLK),
    .rst_n  (reset_n),
    .clr    (start),
    .inc    (retire_c),
    .count  (instr_ct),
    .at_max (ins_at_max)
  );

  assign PC      = pc_q;
  assign flags   = flags_q;
  assign running = (state_q == RUN);
  assign halt    = (state_q == HALTED);
  assign cnt_sat = cyc_at_max | ins_at_max;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus halt, saturation and async-reset sequences.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        start, stall, halt_req, jump_en, jump_rel;
  logic [15:0] jump_target;
  logic [7:0]  jump_offset;
  logic [2:0]  flags_in, flags_en;
  logic [15:0] PC;
  logic [2:0]  flags;
  logic        running, halt, cnt_sat;
  logic [15:0] cycle_ct, instr_ct;

  // small-counter instance, free-running from its own start
  logic        s_start;
  logic        s_zero = 1'b0;
  logic [15:0] s_tgt  = 16'h0;
  logic [7:0]  s_off  = 8'h0;
  logic [2:0]  s_f3   = 3'b0;
  logic [15:0] s_pc;
  logic [2:0]  s_flags;
  logic        s_running, s_halt, s_sat;
  logic [3:0]  s_cyc, s_ins;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  fetch_unit u_dut (
    .CLK(CLK), .reset_n(reset_n), .start(start), .stall(stall), .halt_req(halt_req),
    .jump_en(jump_en), .jump_rel(jump_rel), .jump_target(jump_target),
    .jump_offset(jump_offset), .flags_in(flags_in), .flags_en(flags_en),
    .PC(PC), .flags(flags), .running(running), .halt(halt),
    .cycle_ct(cycle_ct), .instr_ct(instr_ct), .cnt_sat(cnt_sat)
  );

  fetch_unit #(.CNT_W(4)) u_small (
    .CLK(CLK), .reset_n(reset_n), .start(s_start), .stall(s_zero), .halt_req(s_zero),
    .jump_en(s_zero), .jump_rel(s_zero), .jump_target(s_tgt),
    .jump_offset(s_off), .flags_in(s_f3), .flags_en(s_f3),
    .PC(s_pc), .flags(s_flags), .running(s_running), .halt(s_halt),
    .cycle_ct(s_cyc), .instr_ct(s_ins), .cnt_sat(s_sat)
  );

  typedef struct {
    string       name;
    logic        st, sl, hr, je, jr;
    logic [15:0] tgt;
    logic [7:0]  off;
    logic [2:0]  fin, fen;
    logic [15:0] pc;
    logic [2:0]  fl;
    logic        run, hlt;
    logic [15:0] cyc, ins;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic st, sl, hr, je, jr,
                     input logic [15:0] tgt, input logic [7:0] off,
                     input logic [2:0] fin, fen, input logic [15:0] pc,
                     input logic [2:0] fl, input logic run, hlt,
                     input logic [15:0] cyc, ins);
    vec_t v;
    v.name = name; v.st = st; v.sl = sl; v.hr = hr; v.je = je; v.jr = jr;
    v.tgt = tgt; v.off = off; v.fin = fin; v.fen = fen; v.pc = pc; v.fl = fl;
    v.run = run; v.hlt = hlt; v.cyc = cyc; v.ins = ins;
    vq.push_back(v);
  endtask

  task automatic drive(input logic st, sl, hr, je, jr, input logic [15:0] tgt,
                       input logic [7:0] off, input logic [2:0] fin, fen);
    start = st; stall = sl; halt_req = hr; jump_en = je; jump_rel = jr;
    jump_target = tgt; jump_offset = off; flags_in = fin; flags_en = fen;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all(input string n, input logic [15:0] pc, input logic [2:0] fl,
                           input logic run, hlt, input logic [15:0] cyc, ins, input logic sat);
    chk({n, ".PC"}, 32'(PC), 32'(pc));
    chk({n, ".flags"}, 32'(flags), 32'(fl));
    chk({n, ".running"}, 32'(running), 32'(run));
    chk({n, ".halt"}, 32'(halt), 32'(hlt));
    chk({n, ".cycle_ct"}, 32'(cycle_ct), 32'(cyc));
    chk({n, ".instr_ct"}, 32'(instr_ct), 32'(ins));
    chk({n, ".cnt_sat"}, 32'(cnt_sat), 32'(sat));
  endtask

  initial begin
    reset_n = 1'b0;
    s_start = 1'b0;
    drive(0, 0, 0, 0, 0, 16'h0, 8'h0, 3'b0, 3'b0);
    #12;
    check_all("reset", 16'h0, 3'b0, 0, 0, 16'd0, 16'd0, 0);
    reset_n = 1'b1;
    tick();

    //   name       st sl hr je jr tgt      off    fin     fen     pc       fl      run hlt cyc ins
    add("idle",     0, 0, 1, 1, 0, 16'h55,  8'h0,  3'b111, 3'b111, 16'h0,   3'b000, 0, 0, 0,  0);
    add("start",    1, 0, 1, 0, 0, 16'h0,   8'h0,  3'b111, 3'b111, 16'h0,   3'b000, 1, 0, 0,  0);
    for (int i = 1; i <= 10; i++)
      add("inc",    0, 0, 0, 0, 0, 16'h0,   8'h0,  3'b0,   3'b0,   16'(i),  3'b000, 1, 0, 16'(i), 16'(i));
    add("jabs",     0, 0, 0, 1, 0, 16'h40,  8'h0,  3'b0,   3'b0,   16'h40,  3'b000, 1, 0, 11, 11);
    add("jrel_neg", 0, 0, 0, 1, 1, 16'h99,  8'hFC, 3'b0,   3'b0,   16'h3C,  3'b000, 1, 0, 12, 12);
    add("jabs2",    0, 0, 0, 1, 0, 16'h2,   8'h0,  3'b0,   3'b0,   16'h2,   3'b000, 1, 0, 13, 13);
    add("jrel_wrap",0, 0, 0, 1, 1, 16'h0,   8'hFC, 3'b0,   3'b0,   16'hFFFE,3'b000, 1, 0, 14, 14);
    add("inc_top",  0, 0, 0, 0, 0, 16'h0,   8'h0,  3'b0,   3'b0,   16'hFFFF,3'b000, 1, 0, 15, 15);
    add("inc_wrap", 0, 0, 0, 0, 0, 16'h0,   8'h0,  3'b0,   3'b0,   16'h0,   3'b000, 1, 0, 16, 16);
    for (int i = 0; i < 3; i++)
      add("stall",  0, 1, 1, 1, 0, 16'h77,  8'h0,  3'b111, 3'b111, 16'h0,   3'b000, 1, 0, 16'(17 + i), 16);
    add("flag_en1", 0, 0, 0, 0, 0, 16'h0,   8'h0,  3'b111, 3'b010, 16'h1,   3'b010, 1, 0, 20, 17);
    add("flag_hold",0, 0, 0, 0, 0, 16'h0,   8'h0,  3'b101, 3'b000, 16'h2,   3'b010, 1, 0, 21, 18);
    add("flag_mix", 0, 0, 0, 0, 0, 16'h0,   8'h0,  3'b001, 3'b101, 16'h3,   3'b011, 1, 0, 22, 19);
    add("stall_fl", 0, 1, 0, 0, 0, 16'h0,   8'h0,  3'b000, 3'b111, 16'h3,   3'b011, 1, 0, 23, 19);
    add("halt",     0, 0, 1, 1, 0, 16'h88,  8'h0,  3'b100, 3'b100, 16'h3,   3'b111, 0, 1, 24, 20);

    foreach (vq[k]) begin
      drive(vq[k].st, vq[k].sl, vq[k].hr, vq[k].je, vq[k].jr, vq[k].tgt, vq[k].off,
            vq[k].fin, vq[k].fen);
      tick();
      check_all(vq[k].name, vq[k].pc, vq[k].fl, vq[k].run, vq[k].hlt, vq[k].cyc, vq[k].ins, 0);
    end

    // HALTED freezes everything for 10 cycles whatever the inputs
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'(i % 2), 0, 1, 1'(i % 3 == 0), 16'h77, 8'h10, 3'b000, 3'b111);
      tick();
    end
    check_all("halted_hold", 16'h3, 3'b111, 0, 1, 16'd24, 16'd20, 0);

    // start with halt_req: start wins
    drive(1, 0, 1, 1, 0, 16'h55, 8'h0, 3'b111, 3'b111);
    tick();
    check_all("start_halt", 16'h0, 3'b000, 1, 0, 16'd0, 16'd0, 0);

    // saturation on the 4-bit instance
    drive(0, 0, 0, 0, 0, 16'h0, 8'h0, 3'b0, 3'b0);
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("small_start_cyc", 32'(s_cyc), 32'd0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("small_cyc", 32'(s_cyc), (i >= 15) ? 32'd15 : 32'(i));
      chk("small_sat", 32'(s_sat), (i >= 15) ? 32'd1 : 32'd0);
    end
    chk("small_ins", 32'(s_ins), 32'd15);
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("small_clr_cyc", 32'(s_cyc), 32'd0);
    chk("small_clr_ins", 32'(s_ins), 32'd0);
    chk("small_clr_sat", 32'(s_sat), 32'd0);

    // async reset mid-run at PC=0x0123
    drive(0, 0, 0, 1, 0, 16'h0123, 8'h0, 3'b0, 3'b0);
    tick();
    drive(0, 1, 0, 0, 0, 16'h0, 8'h0, 3'b0, 3'b0);
    chk("pre_rst_pc", 32'(PC), 32'h123);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_pc", 32'(PC), 32'h0);
    chk("async_rst_run", 32'(running), 32'd0);
    chk("async_rst_cyc", 32'(cycle_ct), 32'd0);
    #1 reset_n = 1'b1;
    drive(0, 0, 0, 1, 0, 16'h0456, 8'h0, 3'b111, 3'b111);
    for (int i = 0; i < 3; i++) tick();
    check_all("post_rst_idle", 16'h0, 3'b000, 0, 0, 16'd0, 16'd0, 0);
    drive(1, 0, 0, 0, 0, 16'h0, 8'h0, 3'b0, 3'b0);
    tick();
    drive(0, 0, 0, 0, 0, 16'h0, 8'h0, 3'b0, 3'b0);
    tick();
    check_all("restart", 16'h1, 3'b000, 1, 0, 16'd1, 16'd1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
